// File: rtl/usb_uart_client_fifo.sv
// CPU-side client of the USB UART byte interface, with TX and RX FIFOs so CPU port accesses never stall.
// Optional build macro USB_UART_CLIENT_ERRCNT_EN adds saturating tx_drop_cnt / rx_under_cnt outputs.
module usb_uart_client_fifo #(
   parameter int TX_AW = 4,
   parameter int RX_AW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tx_wr,
   input  logic [7:0]     tx_data,
   output logic           tx_full,
   output logic [TX_AW:0] tx_level,
   input  logic           rx_rd,
   output logic [7:0]     rx_data,
   output logic           rx_empty,
   output logic [RX_AW:0] rx_level,
   output logic           uart_wr,
   output logic [7:0]     uart_tx_data,
   input  logic           uart_busy,
   output logic           uart_rd,
   input  logic [7:0]     uart_rx_data,
   input  logic           uart_valid
`ifdef USB_UART_CLIENT_ERRCNT_EN
   ,
   output logic [7:0]     tx_drop_cnt,
   output logic [7:0]     rx_under_cnt
`endif
);

   localparam logic [TX_AW:0]   TX_DEPTH    = {1'b1, {TX_AW{1'b0}}};
   localparam logic [TX_AW:0]   TX_LVL_ZERO = {(TX_AW+1){1'b0}};
   localparam logic [TX_AW-1:0] TX_PTR_ONE  = {{(TX_AW-1){1'b0}}, 1'b1};
   localparam logic [RX_AW:0]   RX_DEPTH    = {1'b1, {RX_AW{1'b0}}};
   localparam logic [RX_AW:0]   RX_LVL_ZERO = {(RX_AW+1){1'b0}};
   localparam logic [RX_AW-1:0] RX_PTR_ONE  = {{(RX_AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_ISSUE = 2'd1,
      TX_GUARD = 2'd2
   } tx_state_e;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_GUARD = 1'b1
   } rx_state_e;

   logic [7:0]       tx_mem_q [0:(1<<TX_AW)-1];
   logic [7:0]       rx_mem_q [0:(1<<RX_AW)-1];
   logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [TX_AW:0]   tx_lvl_q, tx_lvl_d;
   logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [RX_AW:0]   rx_lvl_q, rx_lvl_d;
   tx_state_e        tx_state_q;
   rx_state_e        rx_state_q;
   logic             tx_wr_q;
   logic [7:0]       tx_byte_q;
   logic             rst_hold_q;
   logic             tx_full_s, tx_push_s, tx_pop_s;
   logic             rx_full_s, rx_empty_s, rx_push_s, rx_pop_s, uart_rd_s;

   // FIFO flags, push/pop qualification and next pointer/level values
   always_comb begin
      tx_full_s  = (tx_lvl_q == TX_DEPTH);
      tx_push_s  = tx_wr & ~tx_full_s;
      tx_pop_s   = (tx_state_q == TX_IDLE) & (tx_lvl_q != TX_LVL_ZERO) & ~uart_busy;
      rx_full_s  = (rx_lvl_q == RX_DEPTH);
      rx_empty_s = (rx_lvl_q == RX_LVL_ZERO);
      // No read strobe during reset or the cycle after, so the UART never hands over a byte we discard.
      uart_rd_s  = ~reset & ~rst_hold_q & (rx_state_q == RX_IDLE) & uart_valid & ~rx_full_s;
      rx_push_s  = uart_rd_s;
      rx_pop_s   = rx_rd & ~rx_empty_s;

      if (tx_push_s) tx_wp_d = tx_wp_q + TX_PTR_ONE;
      else           tx_wp_d = tx_wp_q;
      if (tx_pop_s)  tx_rp_d = tx_rp_q + TX_PTR_ONE;
      else           tx_rp_d = tx_rp_q;
      tx_lvl_d = tx_lvl_q + {{TX_AW{1'b0}}, tx_push_s} - {{TX_AW{1'b0}}, tx_pop_s};

      if (rx_push_s) rx_wp_d = rx_wp_q + RX_PTR_ONE;
      else           rx_wp_d = rx_wp_q;
      if (rx_pop_s)  rx_rp_d = rx_rp_q + RX_PTR_ONE;
      else           rx_rp_d = rx_rp_q;
      rx_lvl_d = rx_lvl_q + {{RX_AW{1'b0}}, rx_push_s} - {{RX_AW{1'b0}}, rx_pop_s};
   end

   // FIFO storage writes
   always_ff @(posedge clk) begin
      if (tx_push_s) tx_mem_q[tx_wp_q] <= tx_data;
      if (rx_push_s) rx_mem_q[rx_wp_q] <= uart_rx_data;
   end

   // FIFO pointers, levels and the reset-follow flag
   always_ff @(posedge clk) begin
      rst_hold_q <= reset;
      if (reset) begin
         tx_wp_q  <= {TX_AW{1'b0}};
         tx_rp_q  <= {TX_AW{1'b0}};
         tx_lvl_q <= TX_LVL_ZERO;
         rx_wp_q  <= {RX_AW{1'b0}};
         rx_rp_q  <= {RX_AW{1'b0}};
         rx_lvl_q <= RX_LVL_ZERO;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_lvl_q <= tx_lvl_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_lvl_q <= rx_lvl_d;
      end
   end

   // TX engine: IDLE pops the head into uart_tx_data, ISSUE strobes, GUARD lets uart_busy rise
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_wr_q    <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_pop_s) begin
                  tx_byte_q  <= tx_mem_q[tx_rp_q];
                  tx_wr_q    <= 1'b1;
                  tx_state_q <= TX_ISSUE;
               end else begin
                  tx_wr_q    <= 1'b0;
                  tx_state_q <= TX_IDLE;
               end
            end
            TX_ISSUE: begin
               tx_wr_q    <= 1'b0;
               tx_state_q <= TX_GUARD;
            end
            TX_GUARD: begin
               tx_wr_q    <= 1'b0;
               tx_state_q <= TX_IDLE;
            end
            default: begin
               tx_wr_q    <= 1'b0;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   // RX engine: a read in IDLE is followed by one GUARD cycle so uart_valid can drop
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (uart_rd_s) rx_state_q <= RX_GUARD;
               else           rx_state_q <= RX_IDLE;
            end
            RX_GUARD: rx_state_q <= RX_IDLE;
            default:  rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // Output mapping; rx_data reads as zero while the RX FIFO is empty
   always_comb begin
      tx_full      = tx_full_s;
      tx_level     = tx_lvl_q;
      rx_empty     = rx_empty_s;
      rx_level     = rx_lvl_q;
      uart_wr      = tx_wr_q & ~reset;
      uart_tx_data = tx_byte_q;
      uart_rd      = uart_rd_s;
      if (rx_empty_s) rx_data = 8'h00;
      else            rx_data = rx_mem_q[rx_rp_q];
   end

`ifdef USB_UART_CLIENT_ERRCNT_EN
   logic [7:0] tx_drop_q, rx_under_q;

   // Saturating error counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_drop_q  <= 8'h00;
         rx_under_q <= 8'h00;
      end else begin
         if (tx_wr & tx_full_s & (tx_drop_q != 8'hFF)) tx_drop_q <= tx_drop_q + 8'h01;
         if (rx_rd & rx_empty_s & (rx_under_q != 8'hFF)) rx_under_q <= rx_under_q + 8'h01;
      end
   end

   assign tx_drop_cnt  = tx_drop_q;
   assign rx_under_cnt = rx_under_q;
`endif

endmodule

// File: tb/tb_usb_uart_client_fifo.sv
// Bench for usb_uart_client_fifo: fixed vector table, directed corner sequences, random traffic vs a queue model.
module tb_usb_uart_client_fifo;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_wr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_full;
   logic [4:0] tx_level;
   logic       rx_rd = 1'b0;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic [4:0] rx_level;
   logic       uart_wr;
   logic [7:0] uart_tx_data;
   logic       uart_busy = 1'b0;
   logic       uart_rd;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_valid = 1'b0;
`ifdef USB_UART_CLIENT_ERRCNT_EN
   logic [7:0] tx_drop_cnt, rx_under_cnt;
`endif

   usb_uart_client_fifo #(.TX_AW(4), .RX_AW(4)) dut (
      .clk(clk), .reset(reset),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_level(tx_level),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
      .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
      .uart_rd(uart_rd), .uart_rx_data(uart_rx_data), .uart_valid(uart_valid)
`ifdef USB_UART_CLIENT_ERRCNT_EN
      , .tx_drop_cnt(tx_drop_cnt), .rx_under_cnt(rx_under_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: byte queues plus cycle counts since the last TX pop / RX read.
   logic [7:0] m_txq[$];
   logic [7:0] m_rxq[$];
   int         m_tx_age = 3;
   logic [7:0] m_tx_last = 8'h00;
   bit         m_rx_guard = 1'b0;
   bit         m_post_reset = 1'b0;
   int         m_drop = 0;
   int         m_under = 0;

   logic [7:0] tx_seen[$];
   int         rd_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // One clock cycle: inputs already driven after a negedge; check, clock, update model, return at negedge.
   task automatic cycle(input bit do_chk);
      bit exp_rd, pop;
      int tn, rn;
      #1;
      exp_rd = !reset && !m_post_reset && !m_rx_guard && uart_valid && (m_rxq.size() < 16);
      if (do_chk) begin
         chk("tx_level", tx_level, m_txq.size());
         chk("tx_full", tx_full, m_txq.size() == 16);
         chk("rx_level", rx_level, m_rxq.size());
         chk("rx_empty", rx_empty, m_rxq.size() == 0);
         if (m_rxq.size() > 0) chk("rx_data", rx_data, m_rxq[0]);
         chk("uart_wr", uart_wr, !reset && (m_tx_age == 1));
         chk("uart_tx_data", uart_tx_data, m_tx_last);
         chk("uart_rd", uart_rd, exp_rd);
`ifdef USB_UART_CLIENT_ERRCNT_EN
         chk("tx_drop_cnt", tx_drop_cnt, m_drop);
         chk("rx_under_cnt", rx_under_cnt, m_under);
`endif
      end
      if (uart_wr === 1'b1) tx_seen.push_back(uart_tx_data);
      if (uart_rd === 1'b1) rd_count++;
      @(posedge clk);
      if (reset) begin
         m_txq.delete();
         m_rxq.delete();
         m_tx_age = 3;
         m_tx_last = 8'h00;
         m_rx_guard = 1'b0;
         m_post_reset = 1'b1;
         m_drop = 0;
         m_under = 0;
      end else begin
         tn  = m_txq.size();
         rn  = m_rxq.size();
         pop = (m_tx_age >= 3) && (tn > 0) && !uart_busy;
         if (pop) begin
            m_tx_last = m_txq.pop_front();
            m_tx_age  = 1;
         end else if (m_tx_age < 3) begin
            m_tx_age++;
         end
         if (tx_wr && tn < 16) m_txq.push_back(tx_data);
         if (tx_wr && tn == 16 && m_drop < 255) m_drop++;
         if (rx_rd && rn > 0) void'(m_rxq.pop_front());
         if (rx_rd && rn == 0 && m_under < 255) m_under++;
         if (exp_rd) m_rxq.push_back(uart_rx_data);
         m_rx_guard   = exp_rd;
         m_post_reset = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input bit do_chk);
      reset = 1'b1; tx_wr = 1'b0; rx_rd = 1'b0; uart_busy = 1'b0; uart_valid = 1'b0;
      cycle(do_chk);
      cycle(do_chk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic       tx_wr;
      logic [7:0] tx_data;
      logic       rx_rd;
      logic       busy;
      logic       valid;
      logic [7:0] rx_byte;
      int         e_tx_level;
      logic       e_wr;
      logic [7:0] e_tx_data;
      logic       e_rd;
      int         e_rx_level;
      logic       e_rx_empty;
      logic [7:0] e_rx_data;
   } vec_t;

   vec_t vecs[17];

   initial begin
      // Three back-to-back pushes: strobes three cycles apart carrying 41,42,43
      vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h00};
      vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h00};
      vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'h41, 1'b0, 0, 1'b1, 8'h00};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 8'h41, 1'b0, 0, 1'b1, 8'h00};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 8'h41, 1'b0, 0, 1'b1, 8'h00};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'h42, 1'b0, 0, 1'b1, 8'h00};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h42, 1'b0, 0, 1'b1, 8'h00};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h42, 1'b0, 0, 1'b1, 8'h00};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h43, 1'b0, 0, 1'b1, 8'h00};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 0, 1'b1, 8'h00};
      // Single received byte 55 with valid dropping after the guard cycle, pop, then an underflow pop
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 0, 1'b0, 8'h43, 1'b1, 0, 1'b1, 8'h00};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 0, 1'b0, 8'h43, 1'b0, 1, 1'b0, 8'h55};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 1, 1'b0, 8'h55};
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 1, 1'b0, 8'h55};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 0, 1'b1, 8'h00};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 0, 1'b1, 8'h00};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h43, 1'b0, 0, 1'b1, 8'h00};

      @(negedge clk);
      do_reset(1'b0);
      #1;
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_level", rx_level, 0);
      chk("rst_tx_full", tx_full, 1'b0);
      chk("rst_rx_empty", rx_empty, 1'b1);
      chk("rst_uart_wr", uart_wr, 1'b0);
      chk("rst_uart_rd", uart_rd, 1'b0);
      chk("rst_uart_tx_data", uart_tx_data, 8'h00);
      chk("rst_rx_data", rx_data, 8'h00);

      for (int i = 0; i < 17; i++) begin
         tx_wr = vecs[i].tx_wr; tx_data = vecs[i].tx_data; rx_rd = vecs[i].rx_rd;
         uart_busy = vecs[i].busy; uart_valid = vecs[i].valid; uart_rx_data = vecs[i].rx_byte;
         #1;
         chk($sformatf("vec%0d_tx_level", i), tx_level, vecs[i].e_tx_level);
         chk($sformatf("vec%0d_tx_full", i), tx_full, 1'b0);
         chk($sformatf("vec%0d_uart_wr", i), uart_wr, vecs[i].e_wr);
         chk($sformatf("vec%0d_uart_tx_data", i), uart_tx_data, vecs[i].e_tx_data);
         chk($sformatf("vec%0d_uart_rd", i), uart_rd, vecs[i].e_rd);
         chk($sformatf("vec%0d_rx_level", i), rx_level, vecs[i].e_rx_level);
         chk($sformatf("vec%0d_rx_empty", i), rx_empty, vecs[i].e_rx_empty);
         if (!vecs[i].e_rx_empty) chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].e_rx_data);
         cycle(1'b1);
      end
      tx_wr = 1'b0; rx_rd = 1'b0; uart_valid = 1'b0;
`ifdef USB_UART_CLIENT_ERRCNT_EN
      chk("under_cnt_one", rx_under_cnt, 8'd1);
`endif

      // Busy UART: 17 pushes, the 17th dropped; release busy and expect exactly 00..0F
      do_reset(1'b1);
      uart_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_wr = 1'b1; tx_data = 8'(i);
         cycle(1'b1);
      end
      tx_wr = 1'b0;
      #1;
      chk("full_after_16", tx_full, 1'b1);
      chk("level_16", tx_level, 16);
`ifdef USB_UART_CLIENT_ERRCNT_EN
      chk("drop_cnt_one", tx_drop_cnt, 8'd1);
`endif
      tx_seen.delete();
      uart_busy = 1'b0;
      for (int i = 0; i < 70; i++) cycle(1'b1);
      chk("drain_count", tx_seen.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < tx_seen.size()) chk($sformatf("drain_byte%0d", i), tx_seen[i], 8'(i));
      end
      chk("drain_level", tx_level, 0);

      // RX backpressure: fill to 16, uart_rd withheld, one pop lets exactly one more read through
      do_reset(1'b1);
      uart_valid = 1'b1; uart_rx_data = 8'hA5;
      for (int i = 0; i < 40; i++) cycle(1'b1);
      chk("rx_fill_level", rx_level, 16);
      rd_count = 0;
      for (int i = 0; i < 5; i++) cycle(1'b1);
      chk("rx_full_no_rd", rd_count, 0);
      rx_rd = 1'b1;
      cycle(1'b1);
      rx_rd = 1'b0;
      for (int i = 0; i < 6; i++) cycle(1'b1);
      chk("rx_one_more_rd", rd_count, 1);
      chk("rx_level_back_16", rx_level, 16);
      uart_valid = 1'b0;

      // Reset while TX holds 5 bytes and the engine is issuing
      do_reset(1'b1);
      uart_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_wr = 1'b1; tx_data = 8'(8'h80 + i);
         cycle(1'b1);
      end
      tx_wr = 1'b0; uart_busy = 1'b0;
      cycle(1'b1);
      #1;
      chk("t6_issue_wr", uart_wr, 1'b1);
      chk("t6_issue_level", tx_level, 5);
      reset = 1'b1; uart_valid = 1'b1; uart_rx_data = 8'h3C;
      cycle(1'b1);
      reset = 1'b0;
      #1;
      chk("t6_after_level", tx_level, 0);
      chk("t6_after_wr", uart_wr, 1'b0);
      chk("t6_after_rd", uart_rd, 1'b0);
      cycle(1'b1);
      #1;
      chk("t6_rd_resumes", uart_rd, 1'b1);
      cycle(1'b1);
      uart_valid = 1'b0;

      // Random traffic, alternating push-heavy and pop-heavy phases
      for (int c = 0; c < 3000; c++) begin
         bit push_phase;
         push_phase   = ((c / 400) % 2) == 0;
         reset        = ($urandom_range(0, 299) == 0);
         tx_wr        = push_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
         rx_rd        = push_phase ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
         tx_data      = 8'($urandom);
         uart_busy    = ($urandom_range(0, 9) < 3);
         uart_valid   = ($urandom_range(0, 1) == 1);
         uart_rx_data = 8'($urandom);
         cycle(1'b1);
      end
      reset = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; uart_valid = 1'b0; uart_busy = 1'b0;
      cycle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
